// File: rtl/keycode_event_tracker.sv
// Press/release edge tracker over a multi-slot keycode word feeding a FWFT event FIFO, plus a held mask for watched keys; KEYCODE_RELEASE_EN enables the release phase.
// Capture then one slot per cycle, event is at the head right after its push edge; a stalled consumer holds the head, a push into a full FIFO with no pop is dropped and sets sticky overflow.

module kc_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_vld   = ~w_empty;
  assign o_full  = w_full;
  assign o_dat   = w_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_wr) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_dat;
  end
endmodule

module keycode_event_tracker #(
  parameter int SLOTS  = 2,
  parameter int CODE_W = 8,
  parameter int DEPTH  = 8,
  parameter int WATCH  = 4
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [SLOTS*CODE_W-1:0]   keycode_in,
  input  logic [WATCH*CODE_W-1:0]   watch_codes,
  output logic [WATCH-1:0]          held,
  output logic                      evt_valid,
  output logic [CODE_W-1:0]         evt_code,
  output logic                      evt_press,
  input  logic                      evt_ready,
  output logic                      overflow,
  input  logic                      clr_overflow
);
`ifdef KEYCODE_RELEASE_EN
  localparam int NSTEPS = 2*SLOTS;
  localparam int PBASE  = SLOTS;
  localparam int EW     = CODE_W + 1;
`else
  localparam int NSTEPS = SLOTS;
  localparam int PBASE  = 0;
  localparam int EW     = CODE_W;
`endif
  localparam int IW = $clog2(NSTEPS + 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t                    r_state;
  logic [IW-1:0]             r_idx;
  logic [SLOTS*CODE_W-1:0]   r_snap;
  logic [SLOTS*CODE_W-1:0]   r_cur;
  logic [WATCH-1:0]          r_held;
  logic                      r_ovf;

  logic [CODE_W-1:0]         w_snap [SLOTS];
  logic [CODE_W-1:0]         w_cur  [SLOTS];
  logic [SLOTS-1:0]          w_prs_ok;
  logic                      w_last;
  logic                      w_push;
  logic [EW-1:0]             w_push_dat;
  logic [EW-1:0]             w_head;
  logic                      w_full;
  logic                      w_drop;
  logic [WATCH-1:0]          w_held_nxt;

  for (genvar g = 0; g < SLOTS; g++) begin : g_unpack
    assign w_snap[g] = r_snap[g*CODE_W +: CODE_W];
    assign w_cur[g]  = r_cur[g*CODE_W +: CODE_W];
  end

  // New key: nonzero, not already down, and first occurrence within the word.
  always_comb begin
    w_prs_ok = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_prs_ok[i] = (w_cur[i] != '0);
      for (int k = 0; k < SLOTS; k++) begin
        if (w_snap[k] == w_cur[i])          w_prs_ok[i] = 1'b0;
        if (k < i && w_cur[k] == w_cur[i])  w_prs_ok[i] = 1'b0;
      end
    end
  end

`ifdef KEYCODE_RELEASE_EN
  logic [SLOTS-1:0] w_rel_ok;
  always_comb begin
    w_rel_ok = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_rel_ok[i] = (w_snap[i] != '0);
      for (int k = 0; k < SLOTS; k++) begin
        if (w_cur[k] == w_snap[i])            w_rel_ok[i] = 1'b0;
        if (k < i && w_snap[k] == w_snap[i])  w_rel_ok[i] = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    w_push     = 1'b0;
    w_push_dat = '0;
    if (r_state == S_SCAN) begin
      for (int i = 0; i < SLOTS; i++) begin
`ifdef KEYCODE_RELEASE_EN
        if (r_idx == IW'(i) && w_rel_ok[i]) begin
          w_push     = 1'b1;
          w_push_dat = {1'b0, w_snap[i]};
        end
        if (r_idx == IW'(i + PBASE) && w_prs_ok[i]) begin
          w_push     = 1'b1;
          w_push_dat = {1'b1, w_cur[i]};
        end
`else
        if (r_idx == IW'(i + PBASE) && w_prs_ok[i]) begin
          w_push     = 1'b1;
          w_push_dat = w_cur[i];
        end
`endif
      end
    end
  end

  assign w_last = (r_state == S_SCAN) && (r_idx == IW'(NSTEPS - 1));

  // Evaluated against the word being committed so held moves on the commit edge.
  always_comb begin
    w_held_nxt = '0;
    for (int k = 0; k < WATCH; k++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (watch_codes[k*CODE_W +: CODE_W] != '0 &&
            watch_codes[k*CODE_W +: CODE_W] == (w_last ? w_cur[i] : w_snap[i]))
          w_held_nxt[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_snap  <= '0;
      r_cur   <= '0;
      r_held  <= '0;
    end else begin
      r_held <= w_held_nxt;
      case (r_state)
        S_IDLE: begin
          if (keycode_in != r_snap) begin
            r_cur   <= keycode_in;
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_last) begin
            r_snap  <= r_cur;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  kc_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (evt_ready),
    .o_vld   (evt_valid),
    .o_dat   (w_head),
    .o_full  (w_full)
  );

  assign w_drop = w_push & w_full & ~evt_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    r_ovf <= 1'b0;
    else if (w_drop)       r_ovf <= 1'b1;
    else if (clr_overflow) r_ovf <= 1'b0;
  end

  assign held     = r_held;
  assign overflow = r_ovf;
  assign evt_code = w_head[CODE_W-1:0];
`ifdef KEYCODE_RELEASE_EN
  assign evt_press = w_head[CODE_W];
`else
  assign evt_press = 1'b1;
`endif
endmodule

// File: tb/tb_keycode_event_tracker.sv
// Scoreboard bench for keycode_event_tracker: directed keycode words, expected events queued, negedge monitor compares.
module tb_keycode_event_tracker;
`ifdef KEYCODE_RELEASE_EN
  localparam bit REL    = 1'b1;
  localparam int NSTEPS = 4;
  localparam int PBASE  = 2;
`else
  localparam bit REL    = 1'b0;
  localparam int NSTEPS = 2;
  localparam int PBASE  = 0;
`endif

  typedef struct {
    logic [7:0] code;
    logic       press;
    int         cyc;
  } ev_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [15:0] keycode_in;
  logic [31:0] watch_codes;
  logic [3:0]  held;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_press;
  logic        evt_ready;
  logic        overflow;
  logic        clr_overflow;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];

  keycode_event_tracker #(.SLOTS(2), .CODE_W(8), .DEPTH(4), .WATCH(4)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .keycode_in    (keycode_in),
    .watch_codes   (watch_codes),
    .held          (held),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_press     (evt_press),
    .evt_ready     (evt_ready),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic p, input int cy);
    exp_q.push_back('{c, p, cy});
  endtask

  task automatic at_neg(input int e);
    while (cyc < e) begin
      @(posedge clk_clk);
      #1;
    end
    @(negedge clk_clk);
  endtask

  task automatic drive_word(input logic [15:0] w, output int e0);
    @(posedge clk_clk);
    #1;
    keycode_in = w;
    e0 = cyc + 1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d events never appeared, required 0 outstanding", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk_clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_held"},      32'(held),      32'h0);
    chk({tag, "_evt_valid"}, 32'(evt_valid), 32'h0);
    chk({tag, "_evt_code"},  32'(evt_code),  32'h0);
    chk({tag, "_evt_press"}, 32'(evt_press), REL ? 32'h0 : 32'h1);
    chk({tag, "_overflow"},  32'(overflow),  32'h0);
  endtask

  // Monitor: pops an expected event whenever the DUT head is accepted.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got code %0h press %0b, none expected (cycle %0d)",
                   evt_code, evt_press, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("evt_code", 32'(evt_code), 32'(e.code));
          chk("evt_press", 32'(evt_press), 32'(e.press));
          if (e.cyc >= 0) chk("evt_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    reset_reset_n = 1'b0;
    keycode_in    = 16'h0000;
    watch_codes   = 32'h1A16_0704;
    evt_ready     = 1'b1;
    clr_overflow  = 1'b0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk_reset("reset");
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clk_clk);

    // 1: single press of 0x1A
    drive_word(16'h001A, e0);
    expect_ev(8'h1A, 1'b1, e0 + 1 + PBASE);
    at_neg(e0 + NSTEPS - 1);
    chk("s1_held_before", 32'(held), 32'h0);
    at_neg(e0 + NSTEPS);
    chk("s1_held_after", 32'(held), 32'h8);
    wait_drain();

    // 2: release 0x1A then press 0x07
    drive_word(16'h0700, e0);
    if (REL) expect_ev(8'h1A, 1'b0, e0 + 1);
    expect_ev(8'h07, 1'b1, e0 + 2 + PBASE);
    at_neg(e0 + NSTEPS);
    chk("s2_held", 32'(held), 32'h2);
    wait_drain();

    // 3: fill FIFO with consumer stalled, overflow, clear, drain
    drive_word(16'h0004, e0);
    if (REL) expect_ev(8'h07, 1'b0, e0 + 2);
    expect_ev(8'h04, 1'b1, e0 + 1 + PBASE);
    wait_drain();
    chk("s3_ovf_initial", 32'(overflow), 32'h0);
    evt_ready = 1'b0;
    drive_word(16'h0016, e0);
    if (REL) expect_ev(8'h04, 1'b0, -1);
    expect_ev(8'h16, 1'b1, -1);
    repeat (NSTEPS + 3) @(posedge clk_clk);
    drive_word(16'h1A07, e0);
    if (REL) expect_ev(8'h16, 1'b0, -1);
    expect_ev(8'h07, 1'b1, -1);
    if (!REL) expect_ev(8'h1A, 1'b1, -1);
    repeat (NSTEPS + 3) @(posedge clk_clk);
    drive_word(16'h0405, e0);
    if (!REL) expect_ev(8'h05, 1'b1, -1);
    repeat (NSTEPS + 3) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("s3_ovf_set", 32'(overflow), 32'h1);
    chk("s3_full_valid", 32'(evt_valid), 32'h1);
    chk("s3_head_code", 32'(evt_code), REL ? 32'h04 : 32'h16);
    chk("s3_head_press", 32'(evt_press), REL ? 32'h0 : 32'h1);
    @(posedge clk_clk);
    #1;
    clr_overflow = 1'b1;
    @(posedge clk_clk);
    #1;
    clr_overflow = 1'b0;
    @(negedge clk_clk);
    chk("s3_ovf_cleared", 32'(overflow), 32'h0);
    @(posedge clk_clk);
    #1;
    evt_ready = 1'b1;
    wait_drain();

    // 4: duplicate code in one word yields one press
    drive_word(16'h0000, e0);
    if (REL) begin
      expect_ev(8'h05, 1'b0, e0 + 1);
      expect_ev(8'h04, 1'b0, e0 + 2);
    end
    wait_drain();
    drive_word(16'h1A1A, e0);
    expect_ev(8'h1A, 1'b1, e0 + 1 + PBASE);
    at_neg(e0 + NSTEPS);
    chk("s4_held", 32'(held), 32'h8);
    wait_drain();

    // 5: reset mid-scan, then word reported as presses only
    evt_ready = 1'b0;
    drive_word(16'h0016, e0);
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    chk_reset("s5_in_reset");
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    evt_ready = 1'b1;
    e0 = cyc + 1;
    expect_ev(8'h16, 1'b1, e0 + 1 + PBASE);
    at_neg(e0 + NSTEPS);
    chk("s5_held", 32'(held), 32'h4);
    wait_drain();

    // 6: release to empty word, and a change during scan picked up afterwards
    drive_word(16'h001A, e0);
    if (REL) expect_ev(8'h16, 1'b0, e0 + 1);
    expect_ev(8'h1A, 1'b1, e0 + 1 + PBASE);
    at_neg(e0 + NSTEPS);
    chk("s6_held_on", 32'(held), 32'h8);
    wait_drain();
    drive_word(16'h0000, e0);
    if (REL) expect_ev(8'h1A, 1'b0, e0 + 1);
    @(posedge clk_clk);
    #1;
    keycode_in = 16'h001A;
    e1 = e0 + NSTEPS + 1;
    expect_ev(8'h1A, 1'b1, e1 + 1 + PBASE);
    at_neg(e0 + NSTEPS - 1);
    chk("s6_held_during_scan", 32'(held), 32'h8);
    at_neg(e0 + NSTEPS);
    chk("s6_held_cleared", 32'(held), 32'h0);
    wait_drain();
    at_neg(e1 + NSTEPS);
    chk("s6_held_again", 32'(held), 32'h8);

    // 7: watch list change re-evaluates held one cycle later
    @(posedge clk_clk);
    #1;
    watch_codes = 32'h0016_071A;
    @(negedge clk_clk);
    chk("s7_held_before", 32'(held), 32'h8);
    @(negedge clk_clk);
    chk("s7_held_after", 32'(held), 32'h1);

    repeat (5) @(posedge clk_clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/keycode_event_tracker.md
# keycode_event_tracker

Parametrised successor to the single 8-bit keycode PIO export. It samples a packed multi-slot keycode word written by the NIOS II, detects per-key press and release edges, and serialises them into a first-word-fall-through event FIFO. It also maintains a held-key bitmask for a configurable list of watched game keys. It sits between the keycode PIO export and the game-logic FSMs, so that simultaneous keys (for example, steer plus accelerate) are no longer lost.

## Interface
- SLOTS, 2: keycodes per input word; slot i = keycode_in[i*CODE_W +: CODE_W].
- CODE_W, 8: keycode width; code 0 means "no key".
- DEPTH, 8: event FIFO depth; power of two, ≥2.
- WATCH, 4: number of watched keys.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- keycode_in  in  SLOTS*CODE_W  packed keycodes, synchronous to clk_clk.
- watch_codes  in  WATCH*CODE_W  watched codes; slot k selects held[k].
- held  out  WATCH  held[k]=1 while watch code k is present in the committed snapshot.
- evt_valid  out  1  FIFO head valid.
- evt_code  out  CODE_W  head keycode.
- evt_press  out  1  1 = press, 0 = release.
- evt_ready  in  1  consumer accepts the head when evt_valid & evt_ready.
- overflow  out  1  sticky: an event was dropped.
- clr_overflow  in  1  clears overflow.

## Operation
- Registers:
  - snapshot: last committed word.
  - cur: word under scan.
  - state: IDLE or SCAN.
  - idx: scan step index.
- IDLE:
  - If keycode_in != snapshot, capture cur <= keycode_in, set idx <= 0, and enter SCAN.
  - Otherwise remain in IDLE.
- SCAN performs one step per cycle, with 2*SLOTS steps in total:
  - Steps 0..SLOTS-1 (release phase): for old slot j = snapshot slot idx, push a release event if the code is nonzero, absent from every cur slot, and not equal to any lower-indexed snapshot slot.
  - Steps SLOTS..2*SLOTS-1 (press phase): for new slot j = idx-SLOTS, push a press event if cur slot j is nonzero, absent from every snapshot slot, and not equal to any lower-indexed cur slot.
  - At most one push per step.
  - The final step also commits snapshot <= cur, updates held, and returns to IDLE.
- keycode_in changes during SCAN are ignored until IDLE, which compares against the new snapshot. Intermediate words may therefore be skipped; no event is duplicated.
- held[k] = (watch_code k != 0) && (watch_code k equals some snapshot slot). It is registered and updated only on commit or when watch_codes changes, in which case it updates the next cycle.
- FIFO:
  - Push when not full.
  - Push and pop in the same cycle are both accepted, even when the FIFO is full.
  - A push while full without a pop drops the event and sets overflow.
  - clr_overflow clears overflow; if set and clear coincide, set wins.
  - Events are emitted in order: all releases of a word, then all presses, each in slot order.

## Timing
- Reset values:
  - held=0, evt_valid=0, evt_code=0, evt_press=0, overflow=0.
  - FIFO empty, snapshot=0, cur=0, state=IDLE.
- Reset mid-scan abandons the word. Afterwards snapshot=0, so any nonzero keycode_in is reported as presses only.
- Cycle numbering: keycode_in change visible before edge E0; capture occurs at E0; step s executes at edge E0+1+s.
- An event pushed at edge E reaches the FIFO head (evt_valid high) after E when the FIFO was empty. There is no additional registering delay.
- held updates at edge E0+2*SLOTS. The next capture is possible at E0+2*SLOTS+1.
- The FIFO head is stable while evt_valid & !evt_ready.

## Configuration
- KEYCODE_RELEASE_EN:
  - Defined: release phase present; release events generated; SCAN = 2*SLOTS steps.
  - Undefined: release phase compiled out; SCAN = SLOTS steps (press steps only, idx 0..SLOTS-1); evt_press is constant 1; held and snapshot still track releases.

## Test plan
All scenarios use SLOTS=2, CODE_W=8, DEPTH=4, WATCH=4, watch_codes=0x1A_16_07_04, evt_ready=1 unless stated, and KEYCODE_RELEASE_EN defined unless stated.

1. keycode_in 0x0000→0x001A: exactly one event (0x1A, press=1) at edge E0+3. held becomes 0b1000 at E0+4.
2. 0x001A→0x0700: release 0x1A, then press 0x07 (two events, in that order). held becomes 0b0010.
3. evt_ready=0, then words 0x0004→0x0016→0x1A07 to produce 5 events → 4 events held in the FIFO, overflow=1. Draining yields the first 4 events in order. clr_overflow pulse → overflow=0.
4. 0x0000→0x1A1A: a single press event for 0x1A, not two.
5. keycode_in=0x0016; assert reset_reset_n=0 mid-scan, then release it → all outputs 0 during reset. After reset: one press event for 0x16, no release event.
6. Macro undefined, 0x001A→0x0000: no event; held[3] clears after 2 step cycles; SCAN lasts 2 cycles.
